axi_read_arbiter: RTL and testbench



---
 rtl/axi_pkg.sv | 29 ++
 rtl/axi_read_arbiter_decoder.sv | 16 +
 rtl/axi_read_arbiter.sv | 150 +++++++++++++++
 tb/tb_axi_read_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions: read FSM state encoding, slave address map, response codes.
package axi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0000,
        ST_RA_M1      = 4'b0001,
        ST_RD_M1S0    = 4'b0010,
        ST_RD_M1S1    = 4'b0011,
        ST_RA_M0      = 4'b0100,
        ST_RD_M0S0    = 4'b0101,
        ST_RD_M0S1    = 4'b0110,
        ST_DEFAULT_SL = 4'b1101
    } rd_state_t;

    localparam logic [31:0] S0_BASE = 32'h0000_0000;
    localparam logic [31:0] S0_MASK = 32'hFFFF_0000;
    localparam logic [31:0] S1_BASE = 32'h0001_0000;
    localparam logic [31:0] S1_MASK = 32'hFFFF_0000;

    localparam logic [1:0] DECERR = 2'b11;

    // Region test written as a range check so every address bit takes part.
    function automatic logic addr_in_region(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] mask);
        return (addr >= base) && (addr <= (base | ~mask));
    endfunction

endpackage

// File: rtl/axi_read_arbiter_decoder.sv
// Address decoder for one master: one-hot {s0, s1, miss} from the shared address map.
module axi_addr_decoder
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    output logic [2:0]  sel
);

    logic hit_s0;
    logic hit_s1;

    assign hit_s0 = addr_in_region(addr, S0_BASE, S0_MASK);
    assign hit_s1 = addr_in_region(addr, S1_BASE, S1_MASK) && !hit_s0;
    assign sel    = {hit_s0, hit_s1, !(hit_s0 || hit_s1)};

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-channel arbiter / sequencing FSM for the 2x2 AXI interconnect.
// Optional round-robin arbitration on contention is enabled by defining AXI_RD_RR_EN.
module axi_read_arbiter
    import axi_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        ARVALID_M0,
    input  logic        ARVALID_M1,
    input  logic [31:0] ARADDR_M0,
    input  logic [31:0] ARADDR_M1,
    input  logic        ARREADY_S0,
    input  logic        ARREADY_S1,
    input  logic        RVALID_S0,
    input  logic        RVALID_S1,
    input  logic        RLAST_S0,
    input  logic        RLAST_S1,
    input  logic        RREADY_M0,
    input  logic        RREADY_M1,
    output logic [3:0]  CS_R,
    output logic [3:0]  NS_R,
    output logic        ARVALID_S0,
    output logic        ARVALID_S1,
    output logic        ARREADY_M0,
    output logic        ARREADY_M1,
    output logic        RVALID_DS,
    output logic        RLAST_DS
);

    logic [3:0]  cs_q, cs_d;
    logic        gnt_m1_q, gnt_m1_d;
    logic        pick_m1;

    logic [31:0] araddr_m [2];
    logic [2:0]  dec_sel  [2];

    assign araddr_m[0] = ARADDR_M0;
    assign araddr_m[1] = ARADDR_M1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            axi_addr_decoder u_dec (
                .addr (araddr_m[gi]),
                .sel  (dec_sel[gi])
            );
        end
    endgenerate

`ifdef AXI_RD_RR_EN
    logic last_m1_q, last_m1_d;

    // On contention the master that did not win last time goes first.
    assign pick_m1 = ARVALID_M1 && (!ARVALID_M0 || !last_m1_q);

    always_comb begin
        last_m1_d = last_m1_q;
        if ((cs_q == ST_IDLE) && (ARVALID_M0 || ARVALID_M1)) begin
            last_m1_d = pick_m1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_m1_q <= 1'b1;
        end else begin
            last_m1_q <= last_m1_d;
        end
    end
`else
    assign pick_m1 = ARVALID_M1;
`endif

    logic       ra_m1;
    logic       ra_valid;
    logic [2:0] ra_sel;
    logic       ra_ready;

    assign ra_m1 = (cs_q == ST_RA_M1);

    always_comb begin
        cs_d       = cs_q;
        gnt_m1_d   = gnt_m1_q;
        ra_valid   = ra_m1 ? ARVALID_M1 : ARVALID_M0;
        ra_sel     = ra_m1 ? dec_sel[1] : dec_sel[0];
        ra_ready   = 1'b0;
        ARVALID_S0 = 1'b0;
        ARVALID_S1 = 1'b0;
        RVALID_DS  = 1'b0;
        RLAST_DS   = 1'b0;

        case (cs_q)
            ST_IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    gnt_m1_d = pick_m1;
                    cs_d     = pick_m1 ? ST_RA_M1 : ST_RA_M0;
                end
            end
            ST_RA_M0, ST_RA_M1: begin
                // A master that drops ARVALID here simply holds the FSM in ReadAddr.
                if (ra_sel[2]) begin
                    ARVALID_S0 = ra_valid;
                    ra_ready   = ARREADY_S0;
                    if (ra_valid && ARREADY_S0) begin
                        cs_d = ra_m1 ? ST_RD_M1S0 : ST_RD_M0S0;
                    end
                end else if (ra_sel[1]) begin
                    ARVALID_S1 = ra_valid;
                    ra_ready   = ARREADY_S1;
                    if (ra_valid && ARREADY_S1) begin
                        cs_d = ra_m1 ? ST_RD_M1S1 : ST_RD_M0S1;
                    end
                end else if (ra_sel[0]) begin
                    ra_ready = 1'b1;
                    if (ra_valid) begin
                        cs_d = ST_DEFAULT_SL;
                    end
                end
            end
            ST_RD_M1S0: if (RVALID_S0 && RLAST_S0 && RREADY_M1) cs_d = ST_IDLE;
            ST_RD_M1S1: if (RVALID_S1 && RLAST_S1 && RREADY_M1) cs_d = ST_IDLE;
            ST_RD_M0S0: if (RVALID_S0 && RLAST_S0 && RREADY_M0) cs_d = ST_IDLE;
            ST_RD_M0S1: if (RVALID_S1 && RLAST_S1 && RREADY_M0) cs_d = ST_IDLE;
            ST_DEFAULT_SL: begin
                RVALID_DS = 1'b1;
                RLAST_DS  = 1'b1;
                if (gnt_m1_q ? RREADY_M1 : RREADY_M0) begin
                    cs_d = ST_IDLE;
                end
            end
            default: cs_d = ST_IDLE;
        endcase
    end

    assign ARREADY_M1 = ra_ready && (cs_q == ST_RA_M1);
    assign ARREADY_M0 = ra_ready && (cs_q == ST_RA_M0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cs_q     <= ST_IDLE;
            gnt_m1_q <= 1'b0;
        end else begin
            cs_q     <= cs_d;
            gnt_m1_q <= gnt_m1_d;
        end
    end

    assign CS_R = cs_q;
    assign NS_R = cs_d;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: transaction-level model of grant order, decode and state sequence.
module tb_axi_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0;
    logic [31:0] ARADDR_M0 = '0, ARADDR_M1 = '0;
    logic        ARREADY_S0 = 1'b0, ARREADY_S1 = 1'b0;
    logic        RVALID_S0 = 1'b0, RVALID_S1 = 1'b0, RLAST_S0 = 1'b0, RLAST_S1 = 1'b0;
    logic        RREADY_M0 = 1'b0, RREADY_M1 = 1'b0;
    logic [3:0]  CS_R, NS_R;
    logic        ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1, RVALID_DS, RLAST_DS;

    int checks = 0;
    int failures = 0;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
        .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
        .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
        .RVALID_S0(RVALID_S0), .RVALID_S1(RVALID_S1),
        .RLAST_S0(RLAST_S0), .RLAST_S1(RLAST_S1),
        .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
        .CS_R(CS_R), .NS_R(NS_R),
        .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1),
        .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
        .RVALID_DS(RVALID_DS), .RLAST_DS(RLAST_DS)
    );

    always #5 ACLK = ~ACLK;

    // Expected state codes straight from the state table.
    function automatic logic [3:0] ra_code(input int m);
        return (m == 1) ? 4'b0001 : 4'b0100;
    endfunction

    function automatic logic [3:0] rd_code(input int m, input int r);
        if (m == 1) return (r == 0) ? 4'b0010 : 4'b0011;
        return (r == 0) ? 4'b0101 : 4'b0110;
    endfunction

    // 0 = S0, 1 = S1, 2 = decode miss
    function automatic int region(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a < 32'h0002_0000) return 1;
        return 2;
    endfunction

    function automatic logic [5:0] route_outs();
        return {ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1, RVALID_DS, RLAST_DS};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_ar(input int m, input logic v, input logic [31:0] a);
        if (m == 1) begin ARVALID_M1 = v; ARADDR_M1 = a; end
        else        begin ARVALID_M0 = v; ARADDR_M0 = a; end
    endtask

    task automatic drive_arvalid(input int m, input logic v);
        if (m == 1) ARVALID_M1 = v; else ARVALID_M0 = v;
    endtask

    task automatic drive_rready(input int m, input logic v);
        if (m == 1) RREADY_M1 = v; else RREADY_M0 = v;
    endtask

    task automatic drive_arready(input int s, input logic v);
        if (s == 1) ARREADY_S1 = v; else ARREADY_S0 = v;
    endtask

    task automatic drive_slave_r(input int s, input logic rv, input logic rl);
        if (s == 1) begin RVALID_S1 = rv; RLAST_S1 = rl; end
        else        begin RVALID_S0 = rv; RLAST_S0 = rl; end
    endtask

    task automatic clear_inputs();
        ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S0 = 0; ARREADY_S1 = 0;
        RVALID_S0 = 0; RVALID_S1 = 0; RLAST_S0 = 0; RLAST_S1 = 0;
        RREADY_M0 = 0; RREADY_M1 = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        ARESETn = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
    endtask

    // Full read from IDLE: one master, random slave-side latency and R-channel backpressure.
    task automatic run_read(input int m, input logic [31:0] addr, input int beats, input bit other_req);
        int r, n, cnt, guard;
        logic av, rv, rr, act_sv, act_ar, oth_ar;
        r = region(addr);
        $display("read m%0d addr=%h region=%0d beats=%0d", m, addr, r, beats);
        checks++;
        if (CS_R !== 4'b0000) begin
            failures++; $display("FAIL start_idle: CS_R=%b expected %b", CS_R, 4'b0000);
        end
        drive_ar(m, 1'b1, addr);
        tick();
        checks++;
        if (CS_R !== ra_code(m)) begin
            failures++; $display("FAIL ar_state: CS_R=%b expected %b", CS_R, ra_code(m));
        end
        if (r == 2) begin
            #1;
            act_ar = (m == 1) ? ARREADY_M1 : ARREADY_M0;
            oth_ar = (m == 1) ? ARREADY_M0 : ARREADY_M1;
            checks++;
            if ({act_ar, oth_ar, ARVALID_S0, ARVALID_S1} !== 4'b1000) begin
                failures++; $display("FAIL miss_ar: {rdy,oth_rdy,vs0,vs1}=%b expected 1000", {act_ar, oth_ar, ARVALID_S0, ARVALID_S1});
            end
            tick();
            drive_arvalid(m, 1'b0);
            n = $urandom_range(0, 3);
            for (int i = 0; i <= n; i++) begin
                drive_rready(m, (i == n));
                drive_rready(1 - m, 1'($urandom % 2));
                #1;
                checks++;
                if ({CS_R, RVALID_DS, RLAST_DS} !== {4'b1101, 2'b11}) begin
                    failures++; $display("FAIL default_slave: CS_R=%b ds=%b%b expected 1101 11", CS_R, RVALID_DS, RLAST_DS);
                end
                tick();
            end
            drive_rready(0, 1'b0);
            drive_rready(1, 1'b0);
        end else begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                av = 1'($urandom % 2);
                drive_arvalid(m, av);
                #1;
                act_sv = (r == 1) ? ARVALID_S1 : ARVALID_S0;
                act_ar = (m == 1) ? ARREADY_M1 : ARREADY_M0;
                checks++;
                if ({CS_R, act_sv, act_ar} !== {ra_code(m), av, 1'b0}) begin
                    failures++; $display("FAIL ar_wait: CS_R=%b vs=%b rdy=%b expected %b %b 0", CS_R, act_sv, act_ar, ra_code(m), av);
                end
                tick();
            end
            drive_arvalid(m, 1'b1);
            drive_arready(r, 1'b1);
            #1;
            act_sv = (r == 1) ? ARVALID_S1 : ARVALID_S0;
            act_ar = (m == 1) ? ARREADY_M1 : ARREADY_M0;
            oth_ar = (m == 1) ? ARREADY_M0 : ARREADY_M1;
            checks++;
            if ({act_sv, act_ar, oth_ar, (r == 1) ? ARVALID_S0 : ARVALID_S1} !== 4'b1100) begin
                failures++; $display("FAIL ar_handshake: {vs,rdy,oth_rdy,oth_vs}=%b expected 1100", {act_sv, act_ar, oth_ar, (r == 1) ? ARVALID_S0 : ARVALID_S1});
            end
            tick();
            drive_arvalid(m, 1'b0);
            drive_arready(r, 1'b0);
            if (other_req) drive_ar(1 - m, 1'b1, $urandom & 32'h0000_FFFF);
            cnt = 0;
            guard = 0;
            while (cnt < beats && guard < 200) begin
                rv = 1'($urandom_range(0, 2) != 0);
                rr = 1'($urandom % 2);
                drive_slave_r(r, rv, rv && (cnt == beats - 1));
                drive_slave_r(1 - r, 1'($urandom % 2), 1'($urandom % 2));
                drive_rready(m, rr);
                drive_rready(1 - m, 1'($urandom % 2));
                #1;
                checks++;
                if ({CS_R, ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1} !== {rd_code(m, r), 4'b0000}) begin
                    failures++; $display("FAIL data_state: CS_R=%b ar=%b expected %b 0000", CS_R, {ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1}, rd_code(m, r));
                end
                if (rv && rr) cnt++;
                tick();
                guard++;
            end
            if (guard >= 200) begin
                checks++; failures++;
                $display("FAIL data_timeout: beats=%0d expected %0d", cnt, beats);
            end
            RVALID_S0 = 0; RVALID_S1 = 0; RLAST_S0 = 0; RLAST_S1 = 0;
            RREADY_M0 = 0; RREADY_M1 = 0;
        end
        checks++;
        if (CS_R !== 4'b0000) begin
            failures++; $display("FAIL end_idle: CS_R=%b expected 0000", CS_R);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        ARESETn = 1'b0;
        ARVALID_M1 = 1'b1;
        RVALID_S0 = 1'b1;
        tick();
        tick();
        checks++;
        if ({CS_R, route_outs()} !== 10'b0) begin
            failures++; $display("FAIL reset_state: CS_R=%b outs=%b expected 0000 000000", CS_R, route_outs());
        end
        apply_reset();
    endtask

    task automatic test_single();
        run_read(1, 32'h0001_0040, 1, 1'b0);
    endtask

    task automatic test_contention();
        int w, last_m1;
        apply_reset();
        last_m1 = 1;
        drive_ar(0, 1'b1, $urandom & 32'h0000_FFFF);
        drive_ar(1, 1'b1, $urandom & 32'h0000_FFFF);
        for (int k = 0; k < 3; k++) begin
`ifdef AXI_RD_RR_EN
            w = (last_m1 == 1) ? 0 : 1;
`else
            w = 1;
`endif
            last_m1 = w;
            $display("contention round %0d expect grant m%0d", k, w);
            tick();
            checks++;
            if (CS_R !== ra_code(w)) begin
                failures++; $display("FAIL contention_grant: CS_R=%b expected %b", CS_R, ra_code(w));
            end
            ARREADY_S0 = 1'b1;
            #1;
            checks++;
            if ({ARREADY_M1, ARREADY_M0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL contention_ready: {M1,M0}=%b expected %b", {ARREADY_M1, ARREADY_M0}, (w == 1) ? 2'b10 : 2'b01);
            end
            tick();
            ARREADY_S0 = 1'b0;
            drive_arvalid(w, 1'b0);
            RVALID_S0 = 1'b1; RLAST_S0 = 1'b1;
            drive_rready(w, 1'b1);
            tick();
            RVALID_S0 = 1'b0; RLAST_S0 = 1'b0;
            drive_rready(w, 1'b0);
            checks++;
            if (CS_R !== 4'b0000) begin
                failures++; $display("FAIL contention_idle: CS_R=%b expected 0000", CS_R);
            end
            drive_arvalid(w, 1'b1);
        end
        clear_inputs();
    endtask

    task automatic test_burst();
        run_read(0, $urandom & 32'h0000_FFFF, 4, 1'b0);
    endtask

    task automatic test_decode_miss();
        run_read(0, 32'h1000_0000, 1, 1'b0);
        run_read(1, 32'h0002_0000, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_read(1, 32'h0001_0000 | ($urandom & 32'h0000_FFFF), 2, 1'b1);
        #1;
        checks++;
        if (NS_R !== 4'b0100) begin
            failures++; $display("FAIL bubble_next: NS_R=%b expected 0100", NS_R);
        end
        run_read(0, 32'h0000_FFFF, 1, 1'b0);
    endtask

    task automatic test_async_reset();
        drive_ar(1, 1'b1, 32'h0000_0100);
        tick();
        ARREADY_S0 = 1'b1;
        tick();
        ARREADY_S0 = 1'b0;
        RVALID_S0 = 1'b1; RREADY_M1 = 1'b1;
        tick();
        checks++;
        if (CS_R !== 4'b0010) begin
            failures++; $display("FAIL midburst_state: CS_R=%b expected 0010", CS_R);
        end
        #2;
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({CS_R, route_outs()} !== 10'b0) begin
            failures++; $display("FAIL async_reset: CS_R=%b outs=%b expected 0000 000000", CS_R, route_outs());
        end
        clear_inputs();
        tick();
        ARESETn = 1'b1;
        run_read(1, 32'h0000_0200, 2, 1'b0);
    endtask

    task automatic test_illegal();
        ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARREADY_S0 = 1'b1; ARREADY_S1 = 1'b1;
        RVALID_S0 = 1'b1; RLAST_S0 = 1'b1; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        force dut.cs_q = 4'b1000;
        #1;
        checks++;
        if ({NS_R, route_outs()} !== 10'b0) begin
            failures++; $display("FAIL illegal_next: NS_R=%b outs=%b expected 0000 000000", NS_R, route_outs());
        end
        release dut.cs_q;
        clear_inputs();
        tick();
        checks++;
        if ({CS_R, route_outs()} !== 10'b0) begin
            failures++; $display("FAIL illegal_recover: CS_R=%b outs=%b expected 0000 000000", CS_R, route_outs());
        end
    endtask

    task automatic test_random();
        int m, r, beats;
        logic [31:0] a;
        for (int k = 0; k < 10; k++) begin
            m = $urandom_range(0, 1);
            r = $urandom_range(0, 2);
            beats = $urandom_range(1, 4);
            if (r == 0)      a = $urandom & 32'h0000_FFFF;
            else if (r == 1) a = 32'h0001_0000 | ($urandom & 32'h0000_FFFF);
            else             a = 32'h0002_0000 | $urandom;
            run_read(m, a, beats, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_burst();
        test_decode_miss();
        test_back_to_back();
        test_async_reset();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
